// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared grant encoding and wait-counter constants for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DMA} grant_t;
  localparam int WAIT_W = 4;
  localparam int MAX_WAIT_DEF = 4;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of consecutive denied DMA cycles
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [WAIT_W-1:0] cnt;
  assign at_max = cnt == WAIT_W'(MAX);
  always_ff @(posedge clk) begin
    if (!reset || clr) cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + WAIT_W'(1);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU MEM stage and a DMA requester
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  grant_t gnt;
  logic at_max;
  always_comb begin
    gnt = !reset ? GNT_NONE :
          (dma_req && (!cpu_req || at_max)) ? GNT_DMA :
          cpu_req ? GNT_CPU : GNT_NONE;
  end
  assign dma_gnt   = gnt == GNT_DMA;
  assign cpu_stall = cpu_req && dma_gnt;
  assign mem_we    = dma_gnt ? dma_we : (gnt == GNT_CPU) && cpu_we;
  assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign cpu_rdata = mem_rdata;
  arb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (dma_req && !dma_gnt),
    .clr    (dma_gnt || !dma_req),
    .at_max (at_max)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and sequence checks of dmem_arbiter against a word memory model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, cpu_stall, dma_req, dma_we, dma_gnt, dma_rvalid, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic cr, cw;
    logic [31:0] ca, cd;
    logic dr, dw;
    logic [31:0] da, dd;
    logic eg, es, ew;
    logic [31:0] eaddr;
    logic ck;
    logic [31:0] ecrd;
    logic erv;
    logic [31:0] erd;
  } vec_t;
  vec_t vt[22];
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
                              logic eg, logic es, logic ew, logic [31:0] eaddr,
                              logic ck, logic [31:0] ecrd, logic erv, logic [31:0] erd);
    mk = '{cr, cw, ca, cd, dr, dw, da, dd, eg, es, ew, eaddr, ck, ecrd, erv, erd};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  localparam logic [31:0] A = 32'hABCDE02E;
  localparam logic [31:0] B = 32'h12345678;
  localparam logic [31:0] C = 32'hCAFEF00D;
  initial begin
    vt[0]  = mk(1, 1, 132, A,       1, 0, 0, 0,     0, 0, 1, 132,     0, 0, 0, 0);
    vt[1]  = mk(1, 0, 132, 0,       0, 0, 0, 0,     0, 0, 0, 132,     1, A, 0, 0);
    vt[2]  = mk(0, 0, 0, 0,         1, 0, 132, 0,   1, 0, 0, 132,     0, 0, 1, A);
    vt[3]  = mk(0, 0, 0, 0,         0, 0, 0, 0,     0, 0, 0, 0,       0, 0, 0, A);
    for (int i = 4; i < 8; i++)
      vt[i] = mk(1, 0, 'h100, 0,    1, 1, 'h80, B,  0, 0, 0, 'h100,   0, 0, 0, A);
    vt[8]  = mk(1, 1, 'h84, C,      1, 1, 'h80, B,  1, 1, 1, 'h80,    0, 0, 0, A);
    vt[9]  = mk(1, 1, 'h84, C,      0, 0, 0, 0,     0, 0, 1, 'h84,    0, 0, 0, A);
    vt[10] = mk(1, 0, 'h80, 0,      0, 0, 0, 0,     0, 0, 0, 'h80,    1, B, 0, A);
    vt[11] = mk(1, 0, 'h84, 0,      0, 0, 0, 0,     0, 0, 0, 'h84,    1, C, 0, A);
    for (int i = 12; i < 20; i++)
      vt[i] = mk(1, 0, 'h100, 0,    i != 15, 0, 'h80, 0, 0, 0, 0, 'h100, 0, 0, 0, A);
    vt[20] = mk(1, 0, 'h100, 0,     1, 0, 'h80, 0,  1, 1, 0, 'h80,    0, 0, 1, B);
    vt[21] = mk(1, 0, 'h100, 0,     0, 0, 0, 0,     0, 0, 0, 'h100,   0, 0, 0, B);
    reset = 1'b0;
    drive(1, 1, 'h40, 'h5555, 1, 1, 'h44, 'h6666);
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_dma_gnt", 32'(dma_gnt), 0);
      chk("rst_cpu_stall", 32'(cpu_stall), 0);
      tick;
      chk("rst_rvalid", 32'(dma_rvalid), 0);
      chk("rst_rdata", dma_rdata, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
      #3;
      chk($sformatf("v%0d_dma_gnt", i), 32'(dma_gnt), 32'(vt[i].eg));
      chk($sformatf("v%0d_cpu_stall", i), 32'(cpu_stall), 32'(vt[i].es));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].ew));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].eaddr);
      if (vt[i].ck) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vt[i].ecrd);
      tick;
      chk($sformatf("v%0d_rvalid", i), 32'(dma_rvalid), 32'(vt[i].erv));
      chk($sformatf("v%0d_rdata", i), dma_rdata, vt[i].erd);
    end
    drive(1, 0, 'h100, 0, 1, 0, 'h80, 0);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("mw_pre_gnt", 32'(dma_gnt), 0);
      tick;
    end
    reset = 1'b0;
    #3;
    chk("mw_rst_gnt", 32'(dma_gnt), 0);
    chk("mw_rst_stall", 32'(cpu_stall), 0);
    chk("mw_rst_we", 32'(mem_we), 0);
    tick;
    chk("mw_rst_rdata", dma_rdata, 0);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk($sformatf("mw%0d_dma_gnt", k), 32'(dma_gnt), 32'(k == 4));
      chk($sformatf("mw%0d_cpu_stall", k), 32'(cpu_stall), 32'(k == 4));
      tick;
    end
    chk("mw_rvalid", 32'(dma_rvalid), 1);
    chk("mw_rdata", dma_rdata, B);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("mw_rvalid_drop", 32'(dma_rvalid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
